// File: rtl/imem_loader_if.sv
//------------------------------------------------------------------------------
// imem_loader_if : byte-stream input and instruction-memory write bus
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface imem_loader_if;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] word_count;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata,
    input  cpu_hold, busy, done, err, word_count
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata,
    output cpu_hold, busy, done, err, word_count
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
//------------------------------------------------------------------------------
// imem_loader : loads a length-prefixed 16-bit program image into IMEM
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module imem_loader #(
  parameter int          MAX_WORDS = 256,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic          clk,
  input  logic          pc_reset_n,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_WRITE   = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_e;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [7:0]  len_hi_q;
  logic [15:0] len_q;
  logic [7:0]  data_hi_q;
  logic [15:0] idx_q;
  logic        in_ready_q;
  logic        imem_we_q;
  logic [15:0] imem_addr_q;
  logic [15:0] imem_wdata_q;
  logic        cpu_hold_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  logic        fire;
  logic [15:0] len_in;
  logic [15:0] idx_next;

  // in_ready_q always reflects state_q, so this is the exact handshake
  assign fire     = bus.in_valid & in_ready_q;
  assign len_in   = {len_hi_q, bus.in_data};
  assign idx_next = idx_q + 16'd1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (bus.start) state_d = S_LEN_HI;
      S_LEN_HI:              if (fire) state_d = S_LEN_LO;
      S_LEN_LO: begin
        if (fire) begin
          if (len_in == 16'd0)               state_d = S_DONE;
          else if ({1'b0, len_in} > MAX_N)   state_d = S_ERR;
          else                               state_d = S_DATA_HI;
        end
      end
      S_DATA_HI:             if (fire) state_d = S_DATA_LO;
      S_DATA_LO:             if (fire) state_d = S_WRITE;
      S_WRITE:               state_d = (idx_next == len_q) ? S_DONE : S_DATA_HI;
      default:               state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!pc_reset_n) begin
      state_q      <= S_IDLE;
      len_hi_q     <= 8'd0;
      len_q        <= 16'd0;
      data_hi_q    <= 8'd0;
      idx_q        <= 16'd0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= 16'd0;
      imem_wdata_q <= 16'd0;
      cpu_hold_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      // outputs are decoded from the next state so they line up with state_q
      in_ready_q <= (state_d inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO});
      imem_we_q  <= (state_d == S_WRITE);
      busy_q     <= (state_d inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE});
      done_q     <= (state_d == S_DONE);
      err_q      <= (state_d == S_ERR);
      cpu_hold_q <= (state_d != S_DONE);

      if ((state_q inside {S_IDLE, S_DONE, S_ERR}) && bus.start)
        idx_q <= 16'd0;
      if (fire && (state_q == S_LEN_HI))
        len_hi_q <= bus.in_data;
      if (fire && (state_q == S_LEN_LO))
        len_q <= len_in;
      if (fire && (state_q == S_DATA_HI))
        data_hi_q <= bus.in_data;
      if (fire && (state_q == S_DATA_LO)) begin
        imem_addr_q  <= BASE_ADDR + idx_q;
        imem_wdata_q <= {data_hi_q, bus.in_data};
      end
      if (state_q == S_WRITE)
        idx_q <= idx_next;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.cpu_hold   = cpu_hold_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.word_count = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
//------------------------------------------------------------------------------
// tb_imem_loader : directed self-checking bench for imem_loader
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_imem_loader;

  logic clk = 1'b0;
  logic pc_reset_n = 1'b0;

  always #5 clk = ~clk;

  imem_loader_if bus();

  imem_loader #(
    .MAX_WORDS (256),
    .BASE_ADDR (16'h0000)
  ) dut (
    .clk        (clk),
    .pc_reset_n (pc_reset_n),
    .bus        (bus)
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [15:0] wr_addr [1024];
  logic [15:0] wr_data [1024];
  int          wr_n = 0;
  int          base;
  bit          tog;

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (wr_n < 1024) begin
        wr_addr[wr_n] = bus.imem_addr;
        wr_data[wr_n] = bus.imem_wdata;
      end
      wr_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b, input bit toggle);
    int guard;
    bit sent;
    guard = 0;
    sent  = 1'b0;
    while (!sent && guard < 50) begin
      @(negedge clk);
      bus.in_data = b;
      if (toggle) begin
        bus.in_valid = tog;
        tog = ~tog;
      end else begin
        bus.in_valid = 1'b1;
      end
      if (bus.in_valid && bus.in_ready) sent = 1'b1;
      guard++;
    end
    if (!sent) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_in();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_end();
    int g;
    g = 0;
    while (!(bus.done || bus.err) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) chk("end_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"},   32'(bus.in_ready),   32'd0);
    chk({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
    chk({tag, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
    chk({tag, "_imem_wdata"}, 32'(bus.imem_wdata), 32'd0);
    chk({tag, "_cpu_hold"},   32'(bus.cpu_hold),   32'd1);
    chk({tag, "_busy"},       32'(bus.busy),       32'd0);
    chk({tag, "_done"},       32'(bus.done),       32'd0);
    chk({tag, "_err"},        32'(bus.err),        32'd0);
    chk({tag, "_word_count"}, 32'(bus.word_count), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] ib;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    tog          = 1'b1;

    // reset state
    pc_reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    pc_reset_n = 1'b1;

    // two-word load, continuous valid
    base = wr_n;
    do_start();
    chk("t1_hold",  32'(bus.cpu_hold), 32'd1);
    chk("t1_busy",  32'(bus.busy),     32'd1);
    chk("t1_ready", 32'(bus.in_ready), 32'd1);
    push(8'h00, 1'b0); push(8'h02, 1'b0);
    push(8'hA1, 1'b0); push(8'h23, 1'b0);
    push(8'hB4, 1'b0); push(8'h56, 1'b0);
    idle_in();
    wait_end();
    chk("t1_nwr",   32'(wr_n - base),          32'd2);
    chk("t1_addr0", 32'(wr_addr[base]),        32'h0000);
    chk("t1_data0", 32'(wr_data[base]),        32'hA123);
    chk("t1_addr1", 32'(wr_addr[base + 1]),    32'h0001);
    chk("t1_data1", 32'(wr_data[base + 1]),    32'hB456);
    chk("t1_done",  32'(bus.done),             32'd1);
    chk("t1_err",   32'(bus.err),              32'd0);
    chk("t1_hold",  32'(bus.cpu_hold),         32'd0);
    chk("t1_wc",    32'(bus.word_count),       32'd2);
    chk("t1_ready", 32'(bus.in_ready),         32'd0);
    chk("t1_busy",  32'(bus.busy),             32'd0);

    // zero-length load
    base = wr_n;
    do_start();
    chk("t2_done_clr", 32'(bus.done),       32'd0);
    chk("t2_wc_clr",   32'(bus.word_count), 32'd0);
    chk("t2_hold",     32'(bus.cpu_hold),   32'd1);
    push(8'h00, 1'b0); push(8'h00, 1'b0);
    idle_in();
    chk("t2_done", 32'(bus.done),       32'd1);
    chk("t2_nwr",  32'(wr_n - base),    32'd0);
    chk("t2_wc",   32'(bus.word_count), 32'd0);
    chk("t2_hold", 32'(bus.cpu_hold),   32'd0);

    // N = 257 exceeds MAX_WORDS
    base = wr_n;
    do_start();
    push(8'h01, 1'b0); push(8'h01, 1'b0);
    @(negedge clk);
    bus.in_data  = 8'h55;
    bus.in_valid = 1'b1;
    chk("t3_err",   32'(bus.err),      32'd1);
    chk("t3_ready", 32'(bus.in_ready), 32'd0);
    chk("t3_hold",  32'(bus.cpu_hold), 32'd1);
    chk("t3_done",  32'(bus.done),     32'd0);
    chk("t3_busy",  32'(bus.busy),     32'd0);
    repeat (3) @(negedge clk);
    chk("t3_err_hold", 32'(bus.err),    32'd1);
    chk("t3_nwr",      32'(wr_n - base), 32'd0);
    bus.in_valid = 1'b0;

    // same two-word stream with in_valid toggling
    base = wr_n;
    do_start();
    tog = 1'b1;
    push(8'h00, 1'b1); push(8'h02, 1'b1);
    push(8'hA1, 1'b1); push(8'h23, 1'b1);
    push(8'hB4, 1'b1); push(8'h56, 1'b1);
    idle_in();
    wait_end();
    chk("t4_nwr",   32'(wr_n - base),       32'd2);
    chk("t4_addr0", 32'(wr_addr[base]),     32'h0000);
    chk("t4_data0", 32'(wr_data[base]),     32'hA123);
    chk("t4_addr1", 32'(wr_addr[base + 1]), 32'h0001);
    chk("t4_data1", 32'(wr_data[base + 1]), 32'hB456);
    chk("t4_done",  32'(bus.done),          32'd1);

    // N = MAX_WORDS is accepted in full
    base = wr_n;
    do_start();
    push(8'h01, 1'b0); push(8'h00, 1'b0);
    for (int i = 0; i < 256; i++) begin
      ib = 8'(i);
      push(ib, 1'b0);
      push(~ib, 1'b0);
    end
    idle_in();
    wait_end();
    chk("t5_done",    32'(bus.done),             32'd1);
    chk("t5_err",     32'(bus.err),              32'd0);
    chk("t5_wc",      32'(bus.word_count),       32'd256);
    chk("t5_nwr",     32'(wr_n - base),          32'd256);
    chk("t5_addr80",  32'(wr_addr[base + 128]),  32'h0080);
    chk("t5_data80",  32'(wr_data[base + 128]),  32'h807F);
    chk("t5_addrlst", 32'(wr_addr[base + 255]),  32'h00FF);
    chk("t5_datalst", 32'(wr_data[base + 255]),  32'hFF00);

    // reset during the first write of a three-word load
    base = wr_n;
    do_start();
    push(8'h00, 1'b0); push(8'h03, 1'b0);
    push(8'h11, 1'b0); push(8'h22, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h33;
    chk("t6_we_pre", 32'(bus.imem_we), 32'd1);
    pc_reset_n = 1'b0;
    @(negedge clk);
    check_reset("t6_rst");
    bus.in_valid = 1'b0;
    @(negedge clk);
    pc_reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_nwr",   32'(wr_n - base),  32'd1);
    chk("t6_busy",  32'(bus.busy),     32'd0);
    chk("t6_ready", 32'(bus.in_ready), 32'd0);
    base = wr_n;
    do_start();
    push(8'h00, 1'b0); push(8'h01, 1'b0);
    push(8'h5A, 1'b0); push(8'hA5, 1'b0);
    idle_in();
    wait_end();
    chk("t6_nwr2", 32'(wr_n - base),    32'd1);
    chk("t6_addr", 32'(wr_addr[base]),  32'h0000);
    chk("t6_data", 32'(wr_data[base]),  32'h5AA5);

    // start pulsed during DATA_LO is ignored
    base = wr_n;
    do_start();
    push(8'h00, 1'b0); push(8'h01, 1'b0); push(8'hAB, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t7_busy",  32'(bus.busy),     32'd1);
    chk("t7_ready", 32'(bus.in_ready), 32'd1);
    chk("t7_done",  32'(bus.done),     32'd0);
    push(8'hCD, 1'b0);
    idle_in();
    wait_end();
    chk("t7_nwr",  32'(wr_n - base),   32'd1);
    chk("t7_addr", 32'(wr_addr[base]), 32'h0000);
    chk("t7_data", 32'(wr_data[base]), 32'hABCD);

    // start in DONE launches a new load
    do_start();
    chk("t8_hold", 32'(bus.cpu_hold),   32'd1);
    chk("t8_done", 32'(bus.done),       32'd0);
    chk("t8_wc",   32'(bus.word_count), 32'd0);
    base = wr_n;
    push(8'h00, 1'b0); push(8'h01, 1'b0);
    push(8'h12, 1'b0); push(8'h34, 1'b0);
    idle_in();
    wait_end();
    chk("t8_nwr",   32'(wr_n - base),   32'd1);
    chk("t8_addr",  32'(wr_addr[base]), 32'h0000);
    chk("t8_data",  32'(wr_data[base]), 32'h1234);
    chk("t8_done2", 32'(bus.done),      32'd1);
    chk("t8_hold2", 32'(bus.cpu_hold),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: MAX_WORDS, default 256, instruction memory depth in 16-bit words; legal 1..65535.
REQ-002 Parameter: BASE_ADDR, default 16'h0000, first instruction memory word address written.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 pc_reset_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  single-cycle request to begin a load.
REQ-006 in_data  in  8  program byte stream.
REQ-007 in_valid  in  1  in_data valid.
REQ-008 in_ready  out  1  loader accepts a byte this cycle.
REQ-009 imem_we  out  1  instruction memory write strobe, one cycle per word.
REQ-010 imem_addr  out  16  instruction memory word address.
REQ-011 imem_wdata  out  16  instruction word.
REQ-012 cpu_hold  out  1  drives the CPU's active-high pc_reset; 1 holds the CPU.
REQ-013 busy  out  1  load in progress.
REQ-014 done  out  1  last load completed successfully.
REQ-015 err  out  1  last load rejected.
REQ-016 word_count  out  16  words written in the current or last load.

Function
REQ-017 Byte transfer: a byte SHALL be accepted only on a rising edge with in_valid=1 and in_ready=1; no byte is lost or duplicated across in_valid gaps.
REQ-018 Stream format: 16-bit length N (high byte first), then N words (high byte first per word).
REQ-019 States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR.
REQ-020 in_ready SHALL be 1 in LEN_HI, LEN_LO, DATA_HI and DATA_LO, and 0 in all other states.
REQ-021 Transition: IDLE/DONE/ERR + start=1 -> LEN_HI; clears done, err and word_count; sets cpu_hold=1.
REQ-022 start SHALL be ignored in LEN_HI, LEN_LO, DATA_HI, DATA_LO and WRITE.
REQ-023 Transition: LEN_HI + byte -> LEN_LO; LEN_LO + byte -> DONE if N=0, ERR if N>MAX_WORDS, else DATA_HI.
REQ-024 Transition: DATA_HI + byte -> DATA_LO; DATA_LO + byte -> WRITE.
REQ-025 WRITE lasts exactly one cycle: imem_we=1, imem_addr=BASE_ADDR+idx (mod 2^16), imem_wdata={hi,lo}; idx and word_count increment at its end.
REQ-026 Transition out of WRITE: DONE if incremented word_count equals N, else DATA_HI.
REQ-027 imem_we SHALL be 0 outside WRITE; imem_addr and imem_wdata hold their last values outside WRITE.
REQ-028 Throughput: at least 3 cycles per word (DATA_HI, DATA_LO, WRITE) with in_valid held at 1.
REQ-029 busy SHALL be 1 in LEN_HI through WRITE; done=1 only in DONE; err=1 only in ERR.
REQ-030 cpu_hold SHALL be 0 only in DONE; it is 1 in IDLE, all load states and ERR.
REQ-031 Excess bytes after N words are not consumed (in_ready=0 in DONE).
REQ-032 ERR SHALL issue no imem_we; bytes after the length are not consumed.

Reset
REQ-033 pc_reset_n=0 at a rising edge SHALL force IDLE from any state, including mid-load.
REQ-034 Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, err=0, word_count=0, idx=0.
REQ-035 A write in progress SHALL be abandoned on reset; imem_we=0 in the cycle after reset is sampled.

Verification
REQ-036 Reset, start, bytes 00 02 A1 23 B4 56 with in_valid=1 -> writes 0xA123@0x0000 and 0xB456@0x0001, one imem_we each, then done=1, cpu_hold=0, word_count=2.
REQ-037 Start, bytes 00 00 -> DONE on the cycle after the LEN_LO byte, no imem_we, word_count=0, cpu_hold=0.
REQ-038 MAX_WORDS=256, start, bytes 01 01 (N=257) -> err=1, no imem_we, cpu_hold=1, in_ready=0.
REQ-039 Same stream as REQ-036 with in_valid toggled 1/0 every cycle -> identical writes and addresses, done=1.
REQ-040 pc_reset_n=0 after the first word is written in a 3-word load -> all REQ-034 values hold, no further imem_we, and the next start restarts at BASE_ADDR.
REQ-041 start pulsed during DATA_LO -> ignored; start in DONE -> cpu_hold=1 and a new load of 00 01 12 34 writes 0x1234@BASE_ADDR.
